regfile_dump_tx: RTL and testbench

Debug reader for the processor's register file. On a start pulse it walks every register address through one combinational read port, snapshots each word, and serializes address plus data over an 8N1 UART transmit line, so the FPGA board can stream architectural state to a host. It sits beside the datapath, sharing a register-file read port that is idle during debug halts, or using a dedicated third port.

---
 rtl/regfile_dump_tx.sv | 165 ++++++++++++++++
 tb/tb_regfile_dump_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_tx.sv
// regfile_dump_tx: walks every register-file address, snapshots each word and
// streams {address byte, data bytes MSB-first} out of an 8N1 UART line.
module regfile_dump_tx #(
  parameter int ADDRW        = 5,
  parameter int DATAW        = 32,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [DATAW-1:0] rd_data_i,
  output logic [ADDRW-1:0] rd_addr_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int NBYTES = DATAW / 8;
  localparam int FW     = DATAW + 8;
  localparam int CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BCW    = (NBYTES > 0) ? $clog2(NBYTES + 1) : 1;

  localparam logic [CW-1:0]    BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0]   BYTE_LAST = BCW'(NBYTES);
  localparam logic [ADDRW-1:0] IDX_LAST  = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] index_q, index_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic [BCW-1:0]   byteCnt_q, byteCnt_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       addrByte;
  logic [7:0]       curByte;

  // Zero-extend the current register index into the frame's leading address byte
  always_comb begin
    addrByte = '0;
    addrByte[ADDRW-1:0] = index_q;
  end

  // Next-state logic: sequence LOAD -> (START, DATA, STOP) per byte, register by register
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    frame_d   = frame_q;
    byteCnt_d = byteCnt_q;
    bitCnt_d  = bitCnt_q;
    bitIdx_d  = bitIdx_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          index_d = '0;
        end
      end
      LOAD: begin
        frame_d   = {addrByte, rd_data_i};
        byteCnt_d = '0;
        bitCnt_d  = '0;
        state_d   = START;
      end
      START: begin
        if (bitCnt_q == BIT_LAST) begin
          bitCnt_d = '0;
          bitIdx_d = '0;
          state_d  = DATA;
        end else begin
          bitCnt_d = bitCnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bitCnt_q == BIT_LAST) begin
          bitCnt_d = '0;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end else begin
          bitCnt_d = bitCnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bitCnt_q == BIT_LAST) begin
          bitCnt_d = '0;
          if (byteCnt_q != BYTE_LAST) begin
            byteCnt_d = byteCnt_q + 1'b1;
            frame_d   = {frame_q[FW-9:0], 8'h00};
            state_d   = START;
          end else if (index_q != IDX_LAST) begin
            index_d = index_q + 1'b1;
            state_d = LOAD;
          end else begin
            index_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          bitCnt_d = bitCnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  // Line level and busy flag are derived from the upcoming state so they come straight off flops
  always_comb begin
    curByte = frame_d[FW-1 -: 8];
    tx_d    = 1'b1;
    busy_d  = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = curByte[bitIdx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers with immediate (asynchronous) reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      index_q   <= '0;
      frame_q   <= '0;
      byteCnt_q <= '0;
      bitCnt_q  <= '0;
      bitIdx_q  <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      frame_q   <= frame_d;
      byteCnt_q <= byteCnt_d;
      bitCnt_q  <= bitCnt_d;
      bitIdx_q  <= bitIdx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rd_addr_o = index_q;
  assign tx_o      = tx_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_regfile_dump_tx.sv
// tb_regfile_dump_tx: drives dumps of a modelled register file and decodes the UART line.
module tb_regfile_dump_tx;

  localparam int ADDRW    = 5;
  localparam int DATAW    = 32;
  localparam int CPB      = 4;
  localparam int NREG     = 2 ** ADDRW;
  localparam int NBYTES   = DATAW / 8;
  localparam int REG_CYC  = 1 + 10 * CPB * (1 + NBYTES);
  localparam int DUMP_CYC = NREG * REG_CYC;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             start_i;
  logic [DATAW-1:0] rd_data_i;
  logic [ADDRW-1:0] rd_addr_o;
  logic             tx_o;
  logic             busy_o;
  logic             done_o;

  logic [DATAW-1:0] rf [NREG];
  logic [DATAW-1:0] modelWords [NREG];
  byte unsigned     rxq[$];
  byte unsigned     expQ[$];
  int               nChecks = 0;
  int               nFail = 0;
  int               doneCount = 0;
  int               pendReg [2];
  int               pendAt [2];
  logic [DATAW-1:0] pendVal [2];

  regfile_dump_tx #(
    .ADDRW(ADDRW),
    .DATAW(DATAW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .start_i(start_i),
    .rd_data_i(rd_data_i),
    .rd_addr_o(rd_addr_o),
    .tx_o(tx_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  assign rd_data_i = rf[rd_addr_o];

  always #5 clk_i = ~clk_i;

  // Count every done pulse so stray extra dumps are visible
  always @(negedge clk_i) begin
    if (done_o) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Independent UART receiver: mid-bit sampling, discards any byte that overlaps a reset
  always begin : uartMonitor
    logic [7:0] data;
    bit abortByte;
    bit frameOk;
    @(negedge clk_i);
    #1;
    if (rst_ni === 1'b1 && tx_o === 1'b0) begin
      abortByte = 1'b0;
      frameOk   = 1'b1;
      data      = '0;
      repeat (CPB / 2) begin
        @(negedge clk_i); #1;
        if (!rst_ni) abortByte = 1'b1;
      end
      if (tx_o !== 1'b0) frameOk = 1'b0;
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) begin
          @(negedge clk_i); #1;
          if (!rst_ni) abortByte = 1'b1;
        end
        data[k] = tx_o;
      end
      repeat (CPB) begin
        @(negedge clk_i); #1;
        if (!rst_ni) abortByte = 1'b1;
      end
      if (tx_o !== 1'b1) frameOk = 1'b0;
      if (!abortByte) begin
        checkOutput("uartFraming", 64'(frameOk), 64'd1);
        rxq.push_back(data);
      end
    end
  end

  // Reference byte stream of one dump: address byte then data bytes, most significant first
  function automatic void appendDump();
    for (int n = 0; n < NREG; n++) begin
      expQ.push_back(8'(n));
      for (int b = NBYTES - 1; b >= 0; b--) expQ.push_back(modelWords[n][8*b +: 8]);
    end
  endfunction

  task automatic compareStream(input string tag);
    checkOutput({tag, "ByteCount"}, 64'(rxq.size()), 64'(expQ.size()));
    for (int i = 0; i < rxq.size() && i < expQ.size(); i++)
      checkOutput($sformatf("%sByte%0d", tag, i), 64'(rxq[i]), 64'(expQ[i]));
    rxq.delete();
    expQ.delete();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // One dump: start request, stray requests at cycles 100/3000, scheduled RF writes, shape capture
  task automatic applyStimulus(input bit holdStart, output int doneAt, output bit busyAtLoad,
                               output logic [10*CPB-1:0] shape);
    int count;
    count      = 0;
    doneAt     = -1;
    busyAtLoad = 1'b0;
    shape      = '0;
    start_i    = 1'b1;
    while (count < DUMP_CYC + 200 && doneAt < 0) begin
      @(negedge clk_i);
      count++;
      if (!holdStart) start_i = (count == 100 || count == 3000);
      if (count == 1) busyAtLoad = busy_o && (rd_addr_o == '0);
      for (int w = 0; w < 2; w++)
        if (pendAt[w] == count) rf[pendReg[w]] = pendVal[w];
      if (count >= 2 + 4 * 10 * CPB && count <= 1 + 5 * 10 * CPB) shape = {shape[10*CPB-2:0], tx_o};
      if (done_o) doneAt = count;
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int doneAt;
    int dc0;
    bit busyAtLoad;
    bit idleOk;
    logic [10*CPB-1:0] shape;
    logic [10*CPB-1:0] expShape;
    logic [9:0] symbols;
    logic [39:0] firstReg;
    logic [39:0] lastReg;

    rst_ni  = 1'b1;
    start_i = 1'b0;
    for (int w = 0; w < 2; w++) pendAt[w] = -1;
    for (int n = 0; n < NREG; n++) rf[n] = '0;
    #3 rst_ni = 1'b0;
    idleCycles(3);
    checkOutput("resetTx", 64'(tx_o), 64'd1);
    checkOutput("resetBusy", 64'(busy_o), 64'd0);
    checkOutput("resetDone", 64'(done_o), 64'd0);
    checkOutput("resetAddr", 64'(rd_addr_o), 64'd0);
    rst_ni = 1'b1;
    idleCycles(5);

    $display("[TB] full dump with fixed pattern and ignored mid-dump starts");
    for (int n = 0; n < NREG; n++) rf[n] = 32'hA500_0000 | n;
    for (int n = 0; n < NREG; n++) modelWords[n] = rf[n];
    appendDump();
    dc0 = doneCount;
    applyStimulus(1'b0, doneAt, busyAtLoad, shape);
    checkOutput("patternDoneLatency", 64'(doneAt), 64'(DUMP_CYC + 1));
    checkOutput("patternBusyAtLoad", 64'(busyAtLoad), 64'd1);
    idleCycles(300);
    checkOutput("patternSingleDone", 64'(doneCount - dc0), 64'd1);
    checkOutput("patternBusyAfter", 64'(busy_o), 64'd0);
    firstReg = '0;
    lastReg  = '0;
    for (int i = 0; i < 5 && rxq.size() >= 160; i++) begin
      firstReg = {firstReg[31:0], rxq[i]};
      lastReg  = {lastReg[31:0], rxq[155 + i]};
    end
    checkOutput("patternFirstReg", 64'(firstReg), 64'h00A5000000);
    checkOutput("patternLastReg", 64'(lastReg), 64'h1FA500001F);
    compareStream("pattern");

    $display("[TB] random dump with snapshot writes and frame shape");
    for (int n = 0; n < NREG; n++) rf[n] = $urandom;
    rf[0] = 32'h0000_0081;
    if (rf[3] == 32'hDEAD_BEEF) rf[3] = 32'h1234_5678;
    pendReg[0] = 3; pendVal[0] = 32'hDEAD_BEEF; pendAt[0] = 3 * REG_CYC + 3;
    pendReg[1] = 4; pendVal[1] = ~rf[4];        pendAt[1] = 3 * REG_CYC + 3;
    for (int n = 0; n < NREG; n++) begin
      modelWords[n] = rf[n];
      for (int w = 0; w < 2; w++)
        if (pendReg[w] == n && pendAt[w] <= n * REG_CYC + 1) modelWords[n] = pendVal[w];
    end
    appendDump();
    symbols  = {1'b1, 8'h81, 1'b0};
    expShape = '0;
    for (int s = 0; s < 10; s++)
      for (int c = 0; c < CPB; c++) expShape = {expShape[10*CPB-2:0], symbols[s]};
    dc0 = doneCount;
    applyStimulus(1'b0, doneAt, busyAtLoad, shape);
    for (int w = 0; w < 2; w++) pendAt[w] = -1;
    checkOutput("randomDoneLatency", 64'(doneAt), 64'(DUMP_CYC + 1));
    checkOutput("frameShape81", 64'(shape), 64'(expShape));
    idleCycles(300);
    checkOutput("randomSingleDone", 64'(doneCount - dc0), 64'd1);
    compareStream("snapshot");

    $display("[TB] reset in the middle of a dump");
    for (int n = 0; n < NREG; n++) rf[n] = $urandom;
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    idleCycles($urandom_range(50, 5000));
    rst_ni = 1'b0;
    #1;
    checkOutput("midResetTx", 64'(tx_o), 64'd1);
    checkOutput("midResetBusy", 64'(busy_o), 64'd0);
    checkOutput("midResetDone", 64'(done_o), 64'd0);
    checkOutput("midResetAddr", 64'(rd_addr_o), 64'd0);
    idleCycles(3);
    rxq.delete();
    rst_ni = 1'b1;
    idleOk = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || rd_addr_o !== '0) idleOk = 1'b0;
    end
    checkOutput("quietAfterReset", 64'(idleOk), 64'd1);
    checkOutput("noBytesAfterReset", 64'(rxq.size()), 64'd0);

    $display("[TB] back-to-back dumps with start held high");
    for (int n = 0; n < NREG; n++) rf[n] = $urandom;
    for (int n = 0; n < NREG; n++) modelWords[n] = rf[n];
    appendDump();
    appendDump();
    applyStimulus(1'b1, doneAt, busyAtLoad, shape);
    checkOutput("b2bFirstDone", 64'(doneAt), 64'(DUMP_CYC + 1));
    checkOutput("b2bFirstLoad", 64'(busyAtLoad), 64'd1);
    applyStimulus(1'b1, doneAt, busyAtLoad, shape);
    checkOutput("b2bSecondLoadAfterDone", 64'(busyAtLoad), 64'd1);
    checkOutput("b2bSecondDone", 64'(doneAt), 64'(DUMP_CYC + 1));
    start_i = 1'b0;
    idleCycles(300 + DUMP_CYC);
    compareStream("b2b");
    checkOutput("b2bIdleAtEnd", 64'(busy_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
